// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        S_ASSERT,
        S_RELEASE,
        S_RUN
    } e_reset_state;

    localparam int RESET_COUNT_WIDTH = 8;

    // Bits needed to hold 0..max_val; never returns less than 1.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// Async-set flop chain: the source reads as asserted until SYNC_STAGES edges
// after reset, and deasserts only on clk.
module reset_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Merges PLL, external and soft reset requests into one event and releases
// the per-domain reset lines in index order with a programmable gap.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_OUTPUTS = 3,
    parameter int NUM_SOURCES = 2,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SOURCES-1:0]       ext_reset,
    input  logic                         soft_reset,
    output logic [NUM_OUTPUTS-1:0]       reset_out,
    output logic                         ready,
    output logic [RESET_COUNT_WIDTH-1:0] reset_count
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES - 1);
    localparam int STEP_W = cnt_width(STEP_CYCLES - 1);
    localparam int IDX_W  = cnt_width(NUM_OUTPUTS - 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_OUTPUTS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

    logic [NUM_SOURCES-1:0] ext_sync;
    logic                   req;
    logic                   restart;

    e_reset_state                 state_q, state_d;
    logic [HOLD_W-1:0]            hold_q, hold_d;
    logic [STEP_W-1:0]            step_q, step_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NUM_OUTPUTS-1:0]       reset_out_q, reset_out_d;
    logic                         ready_q, ready_d;
    logic [RESET_COUNT_WIDTH-1:0] count_q, count_d;

    for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_sync
        reset_synchronizer #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk     (clk),
            .reset   (reset),
            .async_in(ext_reset[i]),
            .sync_out(ext_sync[i])
        );
    end

    assign req     = (|ext_sync) | soft_reset;
    // A request outside S_ASSERT is a new reset event; inside it only extends the hold.
    assign restart = req && (state_q != S_ASSERT);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        step_d      = step_q;
        idx_d       = idx_q;
        reset_out_d = reset_out_q;
        ready_d     = ready_q;
        count_d     = count_q;

        if (restart) begin
            state_d     = S_ASSERT;
            hold_d      = '0;
            step_d      = '0;
            idx_d       = '0;
            reset_out_d = '1;
            ready_d     = 1'b0;
            if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
        end else begin
            case (state_q)
                S_ASSERT: begin
                    if (req) begin
                        hold_d = '0;
                    end else if (hold_q == HOLD_LAST) begin
                        hold_d         = '0;
                        step_d         = '0;
                        reset_out_d[0] = 1'b0;
                        if (NUM_OUTPUTS == 1) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = S_RELEASE;
                            idx_d   = IDX_ONE;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (step_q == STEP_LAST) begin
                        step_d             = '0;
                        reset_out_d[idx_q] = 1'b0;
                        if (idx_q == IDX_LAST) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                S_RUN: begin
                end
                default: begin
                    state_d     = S_ASSERT;
                    hold_d      = '0;
                    reset_out_d = '1;
                    ready_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_ASSERT;
            hold_q      <= '0;
            step_q      <= '0;
            idx_q       <= '0;
            reset_out_q <= '1;
            ready_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            step_q      <= step_d;
            idx_q       <= idx_d;
            reset_out_q <= reset_out_d;
            ready_q     <= ready_d;
            count_q     <= count_d;
        end
    end

    assign reset_out   = reset_out_q;
    assign ready       = ready_q;
    assign reset_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected outputs tagged with the clk edge
// after which they must hold; a negedge monitor compares and retires them.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ext_reset = 2'b00;
    logic       soft_reset = 1'b0;

    logic [2:0] reset_out;
    logic       ready;
    logic [7:0] reset_count;
    logic [0:0] reset_out1;
    logic       ready1;
    logic [7:0] reset_count1;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int base   = 0;

    typedef struct {
        int         cyc;
        bit         d1;
        logic [2:0] out;
        logic       rdy;
        logic [7:0] cnt;
        string      nm;
    } exp_t;

    exp_t sb[$];

    reset_sequencer u_dut (
        .clk        (clk),
        .reset      (rst),
        .ext_reset  (ext_reset),
        .soft_reset (soft_reset),
        .reset_out  (reset_out),
        .ready      (ready),
        .reset_count(reset_count)
    );

    reset_sequencer #(
        .NUM_OUTPUTS(1),
        .STEP_CYCLES(1)
    ) u_dut1 (
        .clk        (clk),
        .reset      (rst),
        .ext_reset  (2'b00),
        .soft_reset (1'b0),
        .reset_out  (reset_out1),
        .ready      (ready1),
        .reset_count(reset_count1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got out/rdy/cnt=%h expected %h", nm, edge_n - base, act, exp);
        end
    endtask

    function automatic logic [11:0] act_of(input bit d1);
        if (d1) return {2'b00, reset_out1, ready1, reset_count1};
        return {reset_out, ready, reset_count};
    endfunction

    task automatic push(input int rel, input bit d1, input logic [2:0] o,
                        input logic r, input logic [7:0] c, input string nm);
        exp_t e;
        e.cyc = base + rel; e.d1 = d1; e.out = o; e.rdy = r; e.cnt = c; e.nm = nm;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == edge_n) begin
                chk(sb[i].nm, act_of(sb[i].d1), {sb[i].out, sb[i].rdy, sb[i].cnt});
                sb.delete(i);
            end else if (sb[i].cyc < edge_n) begin
                chk({sb[i].nm, "_missed"}, 12'hFFF, 12'h000);
                sb.delete(i);
            end
        end
    end

    task automatic wait_edge(input int abs_edge);
        while (edge_n < abs_edge) @(negedge clk);
    endtask

    task automatic pulse_soft();
        soft_reset = 1'b1;
        @(negedge clk);
        soft_reset = 1'b0;
    endtask

    task automatic push_powerup(input string tag);
        push(1,  0, 3'b111, 0, 8'd0, {tag, "_e1"});
        push(17, 0, 3'b111, 0, 8'd0, {tag, "_e17"});
        push(18, 0, 3'b110, 0, 8'd0, {tag, "_rel0"});
        push(21, 0, 3'b110, 0, 8'd0, {tag, "_e21"});
        push(22, 0, 3'b100, 0, 8'd0, {tag, "_rel1"});
        push(25, 0, 3'b100, 0, 8'd0, {tag, "_e25"});
        push(26, 0, 3'b000, 1, 8'd0, {tag, "_rel2"});
        push(17, 1, 3'b001, 0, 8'd0, {tag, "_n1_e17"});
        push(18, 1, 3'b000, 1, 8'd0, {tag, "_n1_rel"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt;
        int pulse_rel;

        repeat (3) @(negedge clk);
        chk("reset_state", act_of(0), {3'b111, 1'b0, 8'd0});
        chk("reset_state_n1", act_of(1), {3'b001, 1'b0, 8'd0});
        rst  = 1'b0;
        base = edge_n;
        push_powerup("pwr");
        wait_edge(base + 29);

        // soft pulse in S_RUN at edge 30
        push(30, 0, 3'b111, 0, 8'd1, "soft_assert");
        push(45, 0, 3'b111, 0, 8'd1, "soft_hold");
        push(46, 0, 3'b110, 0, 8'd1, "soft_rel0");
        push(53, 0, 3'b100, 0, 8'd1, "soft_e53");
        push(54, 0, 3'b000, 1, 8'd1, "soft_ready");
        pulse_soft();

        // ext_reset[1] rises before edge 64, held for 40 cycles
        wait_edge(base + 63);
        push(65,  0, 3'b000, 1, 8'd1, "ext_sync_lag");
        push(66,  0, 3'b111, 0, 8'd2, "ext_assert");
        push(94,  0, 3'b111, 0, 8'd2, "ext_held");
        push(120, 0, 3'b111, 0, 8'd2, "ext_hold_end");
        push(121, 0, 3'b110, 0, 8'd2, "ext_rel0");
        push(128, 0, 3'b100, 0, 8'd2, "ext_e128");
        push(129, 0, 3'b000, 1, 8'd2, "ext_ready");
        ext_reset[1] = 1'b1;
        wait_edge(base + 103);
        ext_reset[1] = 1'b0;

        // soft pulse at 136, second one on the edge reset_out[1] would release
        wait_edge(base + 135);
        push(136, 0, 3'b111, 0, 8'd3, "race_assert");
        push(152, 0, 3'b110, 0, 8'd3, "race_rel0");
        push(155, 0, 3'b110, 0, 8'd3, "race_pre");
        push(156, 0, 3'b111, 0, 8'd4, "race_req_wins");
        push(172, 0, 3'b110, 0, 8'd4, "race_rel0b");
        push(175, 0, 3'b110, 0, 8'd4, "race_e175");
        push(176, 0, 3'b100, 0, 8'd4, "race_rel1");
        push(180, 0, 3'b000, 1, 8'd4, "race_ready");
        pulse_soft();
        wait_edge(base + 155);
        pulse_soft();

        // async reset between edges while in S_RELEASE
        wait_edge(base + 189);
        push(190, 0, 3'b111, 0, 8'd5, "async_pre_assert");
        push(208, 0, 3'b110, 0, 8'd5, "async_pre_rel");
        pulse_soft();
        wait_edge(base + 208);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", act_of(0), {3'b111, 1'b0, 8'd0});
        chk("async_reset_n1", act_of(1), {3'b001, 1'b0, 8'd0});
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        base = edge_n;
        push_powerup("repwr");
        wait_edge(base + 29);

        // 300 soft pulses from S_RUN: count saturates at 255
        for (int i = 1; i <= 300; i++) begin
            exp_cnt   = (i > 255) ? 255 : i;
            pulse_rel = edge_n + 1 - base;
            push(pulse_rel,      0, 3'b111, 0, exp_cnt[7:0], "sat_assert");
            push(pulse_rel + 24, 0, 3'b000, 1, exp_cnt[7:0], "sat_ready");
            pulse_soft();
            repeat (26) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        if (sb.size() != 0) chk("sb_drained", 12'(sb.size()), 12'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
